// File: rtl/bsg_manycore_pkt_exec.sv
// bsg_manycore_pkt_exec: executes decoded manycore packets through a one-entry store buffer,
// plus the tile freeze register. Define BSG_MANYCORE_PKT_EXEC_ERR_CNT_EN to build the unknown-packet counter.
module bsg_manycore_pkt_exec #(
   parameter int   data_width_p    = 32,
   parameter int   addr_width_p    = 14,
   parameter logic freeze_init_p   = 1'b1,
   parameter int   err_cnt_width_p = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_i,

   input  logic                       v_i,
   input  logic                       pkt_freeze_i,
   input  logic                       pkt_unfreeze_i,
   input  logic                       pkt_unknown_i,
   input  logic                       pkt_remote_store_i,
   input  logic [data_width_p-1:0]    data_i,
   input  logic [addr_width_p-1:0]    addr_i,
   input  logic [data_width_p/8-1:0]  mask_i,
   output logic                       yumi_o,

   output logic                       mem_v_o,
   output logic                       mem_w_o,
   output logic [addr_width_p-1:0]    mem_addr_o,
   output logic [data_width_p-1:0]    mem_data_o,
   output logic [data_width_p/8-1:0]  mem_mask_o,
   input  logic                       mem_yumi_i,

   output logic                       freeze_o,
   output logic [err_cnt_width_p-1:0] err_cnt_o,
   output logic                       err_sticky_o
);

   typedef enum logic {
      e_empty = 1'b0,
      e_full  = 1'b1
   } buf_state_e;

   buf_state_e state_r, state_n;

   // Flag priority: store > freeze > unfreeze > unknown.
   logic is_store, is_freeze, is_unfreeze, is_unknown, is_nop;
   assign is_store    = v_i &  pkt_remote_store_i;
   assign is_freeze   = v_i & ~pkt_remote_store_i &  pkt_freeze_i;
   assign is_unfreeze = v_i & ~pkt_remote_store_i & ~pkt_freeze_i &  pkt_unfreeze_i;
   assign is_unknown  = v_i & ~pkt_remote_store_i & ~pkt_freeze_i & ~pkt_unfreeze_i & pkt_unknown_i;
   assign is_nop      = v_i & ~pkt_remote_store_i & ~pkt_freeze_i & ~pkt_unfreeze_i & ~pkt_unknown_i;

   logic draining, store_zero, store_load, cmd_ok;
   assign draining   = (state_r == e_full) & mem_yumi_i;
   assign store_zero = is_store & (mask_i == '0);
   assign store_load = is_store & ~store_zero & ((state_r == e_empty) | draining);
   // Commands wait for a fully empty buffer so they retire behind all earlier stores.
   assign cmd_ok     = (state_r == e_empty) & (is_freeze | is_unfreeze | is_unknown);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_r <= e_empty;
      else         state_r <= state_n;
   end

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_n = state_r;
      yumi_o  = store_zero | store_load | cmd_ok | is_nop;
      unique case (state_r)
         e_empty: if (store_load) state_n = e_full;
         e_full:  if (draining & ~store_load) state_n = e_empty;
         default: state_n = e_empty;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment; the payload is reset because its
   // reset value is visible on the memory port.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mem_addr_o <= '0;
         mem_data_o <= '0;
         mem_mask_o <= '0;
      end else if (store_load) begin
         mem_addr_o <= addr_i;
         mem_data_o <= data_i;
         mem_mask_o <= mask_i;
      end
   end

   assign mem_v_o = (state_r == e_full);
   assign mem_w_o = mem_v_o;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         freeze_o     <= freeze_init_p;
         err_sticky_o <= 1'b0;
      end else if (cmd_ok) begin
         if (is_freeze)   freeze_o     <= 1'b1;
         if (is_unfreeze) freeze_o     <= 1'b0;
         if (is_unknown)  err_sticky_o <= 1'b1;
      end
   end

`ifdef BSG_MANYCORE_PKT_EXEC_ERR_CNT_EN
   logic [err_cnt_width_p-1:0] err_cnt_r;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         err_cnt_r <= '0;
      else if (cmd_ok & is_unknown & ~(&err_cnt_r))
         err_cnt_r <= err_cnt_r + err_cnt_width_p'(1);
   end

   assign err_cnt_o = err_cnt_r;
`else
   assign err_cnt_o = '0;
`endif

endmodule

// File: doc/bsg_manycore_pkt_exec.md
# bsg_manycore_pkt_exec

Executes the decoded packet stream from the manycore packet decoder, directly downstream of it in the tile's network endpoint. Remote stores are held in a one-entry store buffer and issued to local memory over a valid/yumi handshake. Freeze and unfreeze commands update the tile freeze register in order with stores, and unknown packets are counted and flagged.

## Interface
- data_width_p, 32, store data width; must be a multiple of 8
- addr_width_p, 14, local word address width
- freeze_init_p, 1, value of freeze_o on reset
- err_cnt_width_p, 8, width of the unknown-packet counter

- clk_i  in  1  clock
- reset_i  in  1  reset; one clock, asynchronous, active-high
- v_i  in  1  decoded packet valid
- pkt_freeze_i  in  1  freeze command
- pkt_unfreeze_i  in  1  unfreeze command
- pkt_unknown_i  in  1  unsupported packet
- pkt_remote_store_i  in  1  remote store
- data_i  in  data_width_p  store data
- addr_i  in  addr_width_p  store address
- mask_i  in  data_width_p/8  byte mask
- yumi_o  out  1  input packet consumed this cycle
- mem_v_o  out  1  store request valid
- mem_w_o  out  1  write enable; always equals mem_v_o
- mem_addr_o  out  addr_width_p  request address
- mem_data_o  out  data_width_p  request data
- mem_mask_o  out  data_width_p/8  request byte mask
- mem_yumi_i  in  1  memory accepted the request
- freeze_o  out  1  tile freeze state
- err_cnt_o  out  err_cnt_width_p  unknown-packet count, saturating
- err_sticky_o  out  1  at least one unknown packet seen since reset

## Operation
- Store buffer has two states.
  - EMPTY: mem_v_o = 0.
  - FULL: mem_v_o = 1, and mem_addr_o, mem_data_o and mem_mask_o are registered and held stable until mem_yumi_i.
- A buffer is "draining" when it is FULL and mem_yumi_i = 1.
- Store acceptance: yumi_o = 1 when the buffer is EMPTY, or when it is draining.
  - On accept, the buffer loads the new store and is FULL next cycle. A back-to-back drain and load sustains one store per cycle.
- Zero mask: a store with mask_i = 0 is consumed (yumi_o = 1) and dropped. It does not load the buffer and does not stall.
- Freeze, unfreeze and unknown packets are accepted only when the buffer is EMPTY and not loading, so they take effect after all earlier stores have been accepted by memory.
  - While the buffer is FULL, yumi_o = 0 for these packets, even if it is draining.
- On an accepted command:
  - freeze: freeze_o is set to 1 next cycle.
  - unfreeze: freeze_o is cleared to 0 next cycle.
  - unknown: err_cnt_o is incremented, saturating at all-ones, and err_sticky_o is set.
- Stores execute regardless of freeze_o; this is how program loading into a frozen tile works.
- Flag priority: if more than one packet flag is set, the packet is handled by priority store > freeze > unfreeze > unknown.
- v_i = 1 with no flag set: the packet is consumed with no effect.
- yumi_o is never asserted when v_i = 0.

## Timing
- Reset values:
  - buffer EMPTY, so mem_v_o = 0 and mem_w_o = 0
  - mem_addr_o, mem_data_o, mem_mask_o = 0
  - freeze_o = freeze_init_p
  - err_cnt_o = 0
  - err_sticky_o = 0
- yumi_o is combinational from v_i, the flags, mask_i, the buffer state and mem_yumi_i.
- Latency:
  - store accept to mem_v_o: 1 cycle
  - command accept to freeze_o or err_cnt_o update: 1 cycle
- Reset asserted mid-operation discards a pending store immediately (asynchronously). No memory write is issued for it.
- err_cnt_o holds at 2^err_cnt_width_p − 1 once saturated. err_sticky_o stays 1 until reset.

## Configuration
- BSG_MANYCORE_PKT_EXEC_ERR_CNT_EN
  - Defined: the err_cnt_o counter is implemented as described above.
  - Undefined: no counter register is built and err_cnt_o is constant 0. err_sticky_o and all other behaviour are unchanged.

## Test plan
- Reset release, then hold mem_yumi_i = 1 and drive stores to addr 0x10, 0x11, 0x12 (data 0xA, 0xB, 0xC; mask 0xF) on consecutive cycles -> yumi_o = 1 on all three cycles; mem_v_o = 1 with the matching address and data on the three following cycles.
- Store to 0x20 with mem_yumi_i = 0 for 3 cycles, then a second store presented -> mem outputs hold 0x20 for those 3 cycles; the second store gets yumi_o only in the cycle mem_yumi_i = 1.
- Store followed by unfreeze while memory stalls for 2 cycles -> freeze_o stays 1 until the cycle after the first yumi_o for the unfreeze packet, which comes after the store drains; freeze_o = 0 one cycle later.
- 300 unknown packets with err_cnt_width_p = 8 -> err_cnt_o = 255 and err_sticky_o = 1. With the macro undefined, err_cnt_o = 0 throughout.
- Store with mask 0x0 -> yumi_o = 1 and mem_v_o stays 0.
- Reset asserted while the buffer is FULL -> mem_v_o = 0 immediately, before the next clock edge, and freeze_o = freeze_init_p.
